ps2_key_tracker: RTL and testbench

- Parametrised PS/2 scan-code-set-2 decoder. Sits between the byte-level PS/2 receiver and game control logic.
- Tracks make/break state of NUM_KEYS programmable keys, including E0-extended codes. Filters typematic repeats and skips the E1 Pause sequence.
- Outputs a held-key bitmap plus one-cycle press/release pulses per key; replaces fixed single-key 2-bit encoding.

---
 rtl/ps2_key_tracker_pkg.sv | 26 ++
 rtl/ps2_key_tracker_if.sv | 37 +++
 rtl/ps2_key_tracker_code.sv | 23 ++
 rtl/ps2_key_tracker.sv | 144 ++++++++++++++
 tb/tb_ps2_key_tracker.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker_pkg
// Shared constants and types for the PS/2 scan-code-set-2 key tracker.
//   SC_*       : scan-code prefix bytes and the keyboard self-test code
//   PAUSE_SKIP : bytes still to discard after the E1 that starts Pause
//   state_t    : decoder FSM state, also exported as a debug output
// ---------------------------------------------------------------------------
package ps2_key_tracker_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_BAT   = 8'hAA;

  // Pause is E1 14 77 E1 F0 14 F0 77: seven bytes follow the leading E1.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

endpackage

// File: rtl/ps2_key_tracker_if.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker_if
// Bundle between the PS/2 byte receiver / game logic and the key tracker.
//   rx_data, rx_valid      : byte stream in (master drives)
//   key_held/press/release : per-channel bitmap and one-cycle pulses
//   any_held, first_idx    : summary of key_held
//   other_key, bat_seen    : unmatched-key flag, self-test pulse
// Handshake: rx_valid is a one-cycle strobe with no ready/backpressure; the
// tracker consumes rx_data in every cycle rx_valid is high, so the master
// must hold rx_data stable only for that single cycle.
// ---------------------------------------------------------------------------
interface ps2_key_tracker_if #(
  parameter int NUM_KEYS = 4,
  parameter int IDX_W    = 5
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic                any_held;
  logic [IDX_W-1:0]    first_idx;
  logic                other_key;
  logic                bat_seen;

  modport master (
    output rx_data, rx_valid,
    input  key_held, key_press, key_release, any_held, first_idx,
           other_key, bat_seen
  );

  modport slave (
    input  rx_data, rx_valid,
    output key_held, key_press, key_release, any_held, first_idx,
           other_key, bat_seen
  );
endinterface

// File: rtl/ps2_key_tracker_code.sv
// ---------------------------------------------------------------------------
// ps2_code_match
// Combinational compare of a {ext, code} scan code against every channel of
// KEY_CODES. Duplicate entries simply raise several hit bits.
//   ext_i  : code was preceded by E0
//   code_i : make/break code byte
//   hit_o  : bit i set when channel i matches
// ---------------------------------------------------------------------------
module ps2_code_match #(
  parameter int                    NUM_KEYS  = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h072, 9'h175, 9'h01D, 9'h029}
) (
  input  logic                ext_i,
  input  logic [7:0]          code_i,
  output logic [NUM_KEYS-1:0] hit_o
);
  always_comb begin
    hit_o = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit_o[i] = (KEY_CODES[9*i +: 9] == {ext_i, code_i});
    end
  end
endmodule

// File: rtl/ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// ps2_key_tracker
// Scan-code-set-2 decoder tracking make/break of NUM_KEYS programmable keys,
// including E0-extended codes; filters typematic repeats and skips Pause.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ps2_key_tracker_if slave (byte in, bitmap/pulses out)
//   state_o  : current FSM state (debug)
// All outputs are registered; first_idx trails key_held by one clock.
// ---------------------------------------------------------------------------
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES      = {9'h072, 9'h175, 9'h01D, 9'h029},
  parameter int                    TIMEOUT_CYCLES = 2_500_000,
  parameter int                    IDX_W          = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  ps2_key_tracker_if.slave       bus,
  output state_t                 state_o
);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_q, state_d, eff_state;
  logic [2:0]          skip_q, skip_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [NUM_KEYS-1:0] held_q, held_d, press_q, press_d, rel_q, rel_d;
  logic                other_q, other_d, bat_q, bat_d, any_q, any_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                to_fire, match_ext;
  logic [NUM_KEYS-1:0] hit;

  // A stale prefix is dropped first, so a byte arriving in the same cycle
  // is decoded as if the FSM were already back in IDLE.
  assign to_fire   = (state_q != S_IDLE) && (to_q == TO_W'(TIMEOUT_CYCLES));
  assign eff_state = to_fire ? S_IDLE : state_q;
  assign match_ext = (eff_state == S_EXT) || (eff_state == S_EXT_BRK);

  ps2_code_match #(
    .NUM_KEYS  (NUM_KEYS),
    .KEY_CODES (KEY_CODES)
  ) u_match (
    .ext_i  (match_ext),
    .code_i (bus.rx_data),
    .hit_o  (hit)
  );

  always_comb begin
    state_d = eff_state;
    skip_d  = to_fire ? 3'd0 : skip_q;
    to_d    = (eff_state == S_IDLE || bus.rx_valid) ? '0 : to_q + TO_W'(1);
    held_d  = held_q;
    press_d = '0;
    rel_d   = '0;
    other_d = other_q;
    bat_d   = 1'b0;

    if (bus.rx_valid) begin
      case (eff_state)
        S_IDLE, S_EXT: begin
          if (bus.rx_data == SC_BRK) begin
            state_d = (eff_state == S_EXT) ? S_EXT_BRK : S_BRK;
          end else if (bus.rx_data == SC_EXT) begin
            state_d = S_EXT;
          end else if (eff_state == S_IDLE && bus.rx_data == SC_PAUSE) begin
            state_d = S_SKIP;
            skip_d  = PAUSE_SKIP;
          end else if (eff_state == S_IDLE && bus.rx_data == SC_BAT) begin
            held_d  = '0;
            other_d = 1'b0;
            bat_d   = 1'b1;
          end else begin
            // Make code; held keys produce no pulse, filtering typematic repeat.
            state_d = S_IDLE;
            if (|hit) begin
              press_d = hit & ~held_q;
              held_d  = held_q | hit;
            end else begin
              other_d = 1'b1;
            end
          end
        end
        S_BRK, S_EXT_BRK: begin
          state_d = S_IDLE;
          rel_d   = hit & held_q;
          held_d  = held_q & ~hit;
          if (hit == '0) other_d = 1'b0;
        end
        S_SKIP: begin
          if (skip_q <= 3'd1) begin
            state_d = S_IDLE;
            skip_d  = 3'd0;
          end else begin
            skip_d  = skip_q - 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    any_d = |held_d;
    // Lowest set bit wins: scan downward so the last assignment is the lowest.
    idx_d = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (held_q[i]) idx_d = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      skip_q  <= '0;
      to_q    <= '0;
      held_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      other_q <= 1'b0;
      bat_q   <= 1'b0;
      any_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      to_q    <= to_d;
      held_q  <= held_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      other_q <= other_d;
      bat_q   <= bat_d;
      any_q   <= any_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.key_held    = held_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = rel_q;
  assign bus.any_held    = any_q;
  assign bus.first_idx   = idx_q;
  assign bus.other_key   = other_q;
  assign bus.bat_seen    = bat_q;
  assign state_o         = state_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_tracker
// Directed scenarios followed by random byte streams, checked against a
// prefix-flag reference model of the scan-code-set-2 rules.
// ---------------------------------------------------------------------------
module tb_ps2_key_tracker;
  import ps2_key_tracker_pkg::*;

  localparam int NK = 4;
  localparam int IW = 5;
  localparam int TO = 16;
  localparam logic [NK*9-1:0] KC = {9'h072, 9'h175, 9'h01D, 9'h029};

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_o;

  always #5 clk = ~clk;

  ps2_key_tracker_if #(.NUM_KEYS(NK), .IDX_W(IW)) bus ();

  ps2_key_tracker #(
    .NUM_KEYS       (NK),
    .KEY_CODES      (KC),
    .TIMEOUT_CYCLES (TO),
    .IDX_W          (IW)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [NK-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0]    codes[NK];
  logic [NK-1:0] held_m, press_m, rel_m;
  logic          other_m, bat_m;
  bit            ext_p, brk_p;
  int            skip_left;
  int            gap;

  function automatic logic [NK-1:0] match(input bit e, input logic [7:0] b);
    logic [NK-1:0] h = '0;
    for (int i = 0; i < NK; i++) if (codes[i] == {e, b}) h[i] = 1'b1;
    return h;
  endfunction

  function automatic logic [IW-1:0] lowest(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return IW'(i);
    return '0;
  endfunction

  task automatic model_clear();
    held_m = '0; press_m = '0; rel_m = '0; other_m = 1'b0; bat_m = 1'b0;
    ext_p = 0; brk_p = 0; skip_left = 0; gap = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [NK-1:0] h;
    press_m = '0; rel_m = '0; bat_m = 1'b0;
    if ((ext_p || brk_p || skip_left > 0) && gap >= TO) begin
      ext_p = 0; brk_p = 0; skip_left = 0;
    end
    if (skip_left > 0) begin
      skip_left--;
    end else if (brk_p) begin
      h = match(ext_p, b);
      rel_m  = h & held_m;
      held_m = held_m & ~h;
      if (h == '0) other_m = 1'b0;
      ext_p = 0; brk_p = 0;
    end else if (b == 8'hF0) begin
      brk_p = 1;
    end else if (b == 8'hE0) begin
      ext_p = 1;
    end else if (!ext_p && b == 8'hE1) begin
      skip_left = 7;
    end else if (!ext_p && b == 8'hAA) begin
      held_m = '0; other_m = 1'b0; bat_m = 1'b1;
    end else begin
      h = match(ext_p, b);
      if (h != '0) begin
        press_m = h & ~held_m;
        held_m  = held_m | h;
      end else begin
        other_m = 1'b1;
      end
      ext_p = 0;
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [7:0] b);
    logic [NK-1:0] prev;
    prev = held_m;
    model_byte(b);
    exp_q.push_back(held_m);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    gap = 0;
    check("held",    bus.key_held,    exp_q.pop_front());
    check("press",   bus.key_press,   press_m);
    check("release", bus.key_release, rel_m);
    check("other",   bus.other_key,   other_m);
    check("bat",     bus.bat_seen,    bat_m);
    check("any",     bus.any_held,    |held_m);
    check("fidx",    bus.first_idx,   lowest(prev));
    check("idle_st", state_o == S_IDLE, !(ext_p || brk_p || skip_left > 0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      gap++;
    end
    check("gap_press", bus.key_press,   '0);
    check("gap_rel",   bus.key_release, '0);
    check("gap_held",  bus.key_held,    held_m);
    check("gap_fidx",  bus.first_idx,   lowest(held_m));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_held",  bus.key_held, '0);
    check("rst_press", bus.key_press | bus.key_release, '0);
    check("rst_flags", {bus.any_held, bus.other_key, bus.bat_seen}, '0);
    check("rst_fidx",  bus.first_idx, '0);
    check("rst_state", state_o, S_IDLE);
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] pool[10] = '{8'h29, 8'h1D, 8'h75, 8'h72, 8'hE0,
                           8'hF0, 8'hF0, 8'hE1, 8'hAA, 8'h12};

  initial begin
    for (int i = 0; i < NK; i++) codes[i] = KC[9*i +: 9];
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    model_clear();
    @(negedge clk);
    do_reset();

    // Single key make, typematic repeat, break.
    send(8'h29);
    check("tp1_held", bus.key_held, 4'b0001);
    check("tp1_press", bus.key_press, 4'b0001);
    send(8'h29); send(8'h29);
    send(8'hF0); send(8'h29);
    check("tp1_rel", bus.key_release, 4'b0001);

    // Extended key plus plain key, extended break, first_idx.
    send(8'hE0); send(8'h75);
    check("tp2_press_up", bus.key_press, 4'b0100);
    send(8'h72);
    check("tp2_held", bus.key_held, 4'b1100);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("tp2_rel", bus.key_release, 4'b0100);
    idle(1);
    check("tp2_fidx", bus.first_idx, 5'd3);

    // Plain 75 matches nothing.
    send(8'h75);
    check("tp3_other", bus.other_key, 1'b1);
    send(8'hF0); send(8'h75);
    check("tp3_other_clr", bus.other_key, 1'b0);

    // Pause sequence skipped, then W.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h1D);
    check("tp4_press", bus.key_press, 4'b0010);

    // Timeout boundary: one clock short keeps the prefix, full budget drops it.
    send(8'hE0); idle(TO - 1); send(8'h75);
    check("tp5_ext_kept", bus.key_press, 4'b0100);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); idle(TO); send(8'h75);
    check("tp5_other", bus.other_key, 1'b1);
    check("tp5_held2", bus.key_held[2], 1'b0);

    // Self-test clears held keys without release pulses.
    send(8'h29); send(8'hAA);
    check("tp6_bat", bus.bat_seen, 1'b1);
    check("tp6_held", bus.key_held, 4'b0000);
    idle(1);
    check("tp6_bat_pulse", bus.bat_seen, 1'b0);

    // Reset mid-sequence drops the prefix.
    send(8'hE0);
    do_reset();
    send(8'h29);
    check("tp7_held", bus.key_held, 4'b0001);

    // Random streams.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset();
      else if (r < 20) idle($urandom_range(TO - 2, TO + 2));
      else if (r < 30) idle($urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) send(8'($urandom_range(0, 255)));
      else send(pool[$urandom_range(0, 9)]);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
